// File: rtl/core_seq_ctrl.sv
// Tile-pass sequencer for core: on start, walks WREAD -> KLOAD -> XREAD -> EXEC -> DRAIN -> DONE.
// Registered inst lags state by one cycle, except DRAIN fields, which respond combinationally to valid.
module core_seq_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int timeout = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [10:0] w_base,
    input  logic [10:0] x_base,
    input  logic [10:0] p_base,
    input  logic [10:0] len,
    input  logic        valid,
    output logic [34:0] inst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CW = 16;
    localparam int TW = $clog2(timeout + 1);
    localparam logic [32:0] IDLE_BITS = 33'h1_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_WREAD, S_KLOAD, S_XREAD, S_EXEC, S_DRAIN, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [10:0] k_q, k_d;
    logic [TW-1:0] to_q, to_d;
    logic [10:0] w_base_q, x_base_q, p_base_q, len_q;
    logic        mode_q;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [32:0] inst_q, inst_d;
    logic        accept;
    logic [CW-1:0] len_ext, exec_last;
    logic [10:0] w_addr, x_addr, p_addr;

    assign accept    = (state_q == S_IDLE) && start;
    assign len_ext   = CW'(len_q);
    assign exec_last = len_ext + CW'(row + col - 1);
    assign w_addr    = w_base_q + cnt_q[10:0];
    assign x_addr    = x_base_q + cnt_q[10:0];
    assign p_addr    = p_base_q + k_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        to_d    = to_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    k_d     = '0;
                    to_d    = '0;
                    state_d = (len == 11'd0) ? S_DONE : S_WREAD;
                end
            end
            S_WREAD: begin
                if (cnt_q == CW'(row)) begin
                    state_d = S_KLOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_KLOAD: begin
                if (cnt_q == CW'(col - 1)) begin
                    state_d = S_XREAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_XREAD: begin
                if (cnt_q == len_ext) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_EXEC: begin
                if (cnt_q == exec_last) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                // The idle-run counter only tracks consecutive cycles without valid.
                if (valid) begin
                    to_d = '0;
                    k_d  = k_q + 11'd1;
                    if (k_q == len_q - 11'd1) state_d = S_DONE;
                end else if (to_q == TW'(timeout - 1)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
        // A zero-length request goes straight to DONE without ever raising busy.
        busy_d = (state_d != S_IDLE) && !((state_q == S_IDLE) && (state_d == S_DONE));
    end

    always_comb begin
        inst_d = IDLE_BITS;
        case (state_q)
            S_WREAD: begin
                if (cnt_q < CW'(row)) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = w_addr;
                end
                if (cnt_q != '0) inst_d[0] = 1'b1;
            end
            S_KLOAD: inst_d[1] = 1'b1;
            S_XREAD: begin
                if (cnt_q < len_ext) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = x_addr;
                end
                if (cnt_q != '0) inst_d[0] = 1'b1;
            end
            S_EXEC:  inst_d[2] = 1'b1;
            default: inst_d = IDLE_BITS;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            to_q     <= '0;
            w_base_q <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
            len_q    <= '0;
            mode_q   <= 1'b0;
            inst_q   <= IDLE_BITS;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            to_q    <= to_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept) begin
                w_base_q <= w_base;
                x_base_q <= x_base;
                p_base_q <= p_base;
                len_q    <= len;
                mode_q   <= mode;
            end
        end
    end

    always_comb begin
        inst = {1'b0, mode_q, inst_q};
        if ((state_q == S_DRAIN) && valid) begin
            inst[3]     = 1'b1;
            inst[30:20] = p_addr;
            inst[31]    = 1'b0;
            inst[32]    = 1'b0;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule
